// File: rtl/antilog_shift.sv
// Log-to-linear converter: (1.frac) * 2^char, two-stage valid/ready pipeline.
// Optional build macro ANTILOG_ROUND_EN: round half-up at weight 2^-1 instead of truncating.
module antilog_shift #(
    parameter int unsigned CHAR_W = 4,
    parameter int unsigned FRAC_W = 8,
    parameter int unsigned OUT_W  = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic              in_zero,
    input  logic [CHAR_W-1:0] in_char,
    input  logic [FRAC_W-1:0] in_frac,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_W-1:0]  out_data,
    output logic              out_sat
);

    localparam int unsigned WIDE_W = FRAC_W + (1 << CHAR_W);
    localparam int unsigned INT_W  = WIDE_W - FRAC_W;
    localparam int unsigned SUM_W  = INT_W + 1;

    logic              s1_valid;
    logic [INT_W-1:0]  s1_int;
    logic              s1_zero;
    logic              s1_ovf;
`ifdef ANTILOG_ROUND_EN
    logic              s1_half;
    logic              half_c;
`endif

    logic              s1_adv;
    logic              s2_adv;
    logic [INT_W-1:0]  int_c;
    logic              ovf_c;
    logic [SUM_W-1:0]  sum_c;
    logic [OUT_W-1:0]  data_c;
    logic              sat_c;

    assign s2_adv   = !out_valid || out_ready;
    assign s1_adv   = !s1_valid || s2_adv;
    assign in_ready = s1_adv && !rst;

    // Stage-1 operands: integer part of the shifted mantissa; fraction bits below 2^0 only feed rounding.
    always_comb begin
        int_c  = INT_W'((WIDE_W'({1'b1, in_frac}) << in_char) >> FRAC_W);
        ovf_c  = 32'(in_char) >= OUT_W;
`ifdef ANTILOG_ROUND_EN
        half_c = |((WIDE_W'({1'b1, in_frac}) << in_char) & (WIDE_W'(1) << (FRAC_W - 1)));
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid <= 1'b0;
            s1_int   <= '0;
            s1_zero  <= 1'b0;
            s1_ovf   <= 1'b0;
`ifdef ANTILOG_ROUND_EN
            s1_half  <= 1'b0;
`endif
        end else if (s1_adv) begin
            s1_valid <= in_valid;
            if (in_valid) begin
                s1_int  <= int_c;
                s1_zero <= in_zero;
                s1_ovf  <= ovf_c;
`ifdef ANTILOG_ROUND_EN
                s1_half <= half_c;
`endif
            end
        end
    end

    // Stage-2 result: zero wins, then saturation (including a rounding carry past OUT_W).
    always_comb begin
        data_c = '0;
        sat_c  = 1'b0;
`ifdef ANTILOG_ROUND_EN
        sum_c  = SUM_W'(s1_int) + SUM_W'(s1_half);
`else
        sum_c  = SUM_W'(s1_int);
`endif
        if (s1_zero) begin
            data_c = '0;
            sat_c  = 1'b0;
        end else if (s1_ovf || ((sum_c >> OUT_W) != '0)) begin
            data_c = '1;
            sat_c  = 1'b1;
        end else begin
            data_c = sum_c[OUT_W-1:0];
            sat_c  = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            out_data  <= '0;
            out_sat   <= 1'b0;
        end else if (s2_adv) begin
            out_valid <= s1_valid;
            if (s1_valid) begin
                out_data <= data_c;
                out_sat  <= sat_c;
            end
        end
    end

endmodule

// File: tb/tb_antilog_shift.sv
// Bench for antilog_shift: directed cases plus randomized traffic scored against an arithmetic model.
module tb_antilog_shift;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic        in_zero;
    logic [3:0]  in_char;
    logic [7:0]  in_frac;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] out_data;
    logic        out_sat;

    typedef struct {
        logic [12:0] exp;
        int          cyc;
    } ent_t;

    ent_t        sb[$];
    int          cycle = 0;
    int          vectors = 0;
    int          miscompares = 0;
    logic        chk_lat = 1'b0;
    logic        stall_prev = 1'b0;
    logic [12:0] held = '0;

    antilog_shift dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_zero   (in_zero),
        .in_char   (in_char),
        .in_frac   (in_frac),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_sat   (out_sat)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    // Linear value = floor((256+frac) * 2^char / 256), optionally rounded half-up.
    function automatic logic [12:0] model(input logic z, input logic [3:0] c, input logic [7:0] f);
        longint v;
        longint q;
        v = longint'(256 + int'(f)) << c;
`ifdef ANTILOG_ROUND_EN
        q = (v + 128) >> 8;
`else
        q = v >> 8;
`endif
        if (z) return 13'h0000;
        if (c >= 4'd12 || q >= 4096) return {1'b1, 12'hFFF};
        return {1'b0, q[11:0]};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_word();
        in_zero = ($urandom_range(0, 7) == 0);
        in_char = 4'($urandom_range(0, 15));
        in_frac = 8'($urandom);
    endtask

    // One clock: score transfers seen just before the rising edge, then land on the falling edge.
    task automatic tick(output logic acc);
        logic emit;
        ent_t e;
        #1;
        acc  = in_valid && in_ready;
        emit = out_valid && out_ready;
        if (stall_prev) check("hold", {19'd0, out_valid, out_sat, out_data}, {19'd0, 1'b1, held});
        stall_prev = out_valid && !out_ready;
        held = {out_sat, out_data};
        if (emit) begin
            if (sb.size() == 0) begin
                check("spurious_out", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                check("out_data", 32'(out_data), 32'(e.exp[11:0]));
                check("out_sat", 32'(out_sat), 32'(e.exp[12]));
                if (chk_lat) check("latency", 32'(cycle - e.cyc), 32'd2);
            end
        end
        if (acc) sb.push_back('{exp: model(in_zero, in_char, in_frac), cyc: cycle});
        @(posedge clk);
        cycle++;
        @(negedge clk);
    endtask

    task automatic drain();
        logic acc;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < 30; i++) begin
            if (sb.size() == 0 && !out_valid) break;
            tick(acc);
        end
        check("drain", 32'(sb.size() == 0 && !out_valid), 32'd1);
    endtask

    // Single word through an empty pipeline with out_ready high, checking the result directly.
    task automatic single(input string tag, input logic z, input logic [3:0] c, input logic [7:0] f,
                          input logic [11:0] exp_d, input logic exp_s);
        logic acc;
        in_zero  = z;
        in_char  = c;
        in_frac  = f;
        in_valid = 1'b1;
        acc      = 1'b0;
        for (int i = 0; i < 10 && !acc; i++) tick(acc);
        if (!acc) check({tag, "_accept_timeout"}, 32'd0, 32'd1);
        in_valid = 1'b0;
        check({tag, "_s1_only"}, 32'(out_valid), 32'd0);
        tick(acc);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_data"}, 32'(out_data), 32'(exp_d));
        check({tag, "_sat"}, 32'(out_sat), 32'(exp_s));
        tick(acc);
        check({tag, "_empty"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        logic acc;
        int   n;
        rst       = 1'b1;
        in_valid  = 1'b0;
        in_zero   = 1'b0;
        in_char   = '0;
        in_frac   = '0;
        out_ready = 1'b1;
        #1;
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_sat", 32'(out_sat), 32'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk_lat = 1'b1;

        single("t1", 1'b0, 4'd3, 8'h80, 12'h00C, 1'b0);
`ifdef ANTILOG_ROUND_EN
        single("t2", 1'b0, 4'd0, 8'hFF, 12'h002, 1'b0);
`else
        single("t2", 1'b0, 4'd0, 8'hFF, 12'h001, 1'b0);
`endif
        single("t3_max", 1'b0, 4'd11, 8'h80, 12'hC00, 1'b0);
        single("t3_ovf", 1'b0, 4'd12, 8'h00, 12'hFFF, 1'b1);
        single("t3_zero", 1'b1, 4'd9, 8'h5A, 12'h000, 1'b0);
        single("t3_top", 1'b0, 4'd15, 8'hFF, 12'hFFF, 1'b1);

        // Back-to-back stream at full throughput.
        out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            rand_word();
            in_valid = 1'b1;
            tick(acc);
            check("stream_acc", 32'(acc), 32'd1);
        end
        drain();

        // Downstream stall: exactly two words enter, then in_ready drops.
        chk_lat   = 1'b0;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_word();
        n = 0;
        for (int i = 0; i < 5; i++) begin
            tick(acc);
            if (acc) begin
                n++;
                rand_word();
            end
        end
        check("stall_accepts", 32'(n), 32'd2);
        check("stall_in_ready", 32'(in_ready), 32'd0);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick(acc);
            if (acc) rand_word();
        end
        drain();

        // Randomized traffic on both handshakes.
        in_valid = 1'b0;
        for (int i = 0; i < 400; i++) begin
            if (!in_valid) rand_word();
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            tick(acc);
            if (acc) in_valid = 1'b0;
        end
        drain();

        // Reset with both stages full discards everything in flight.
        out_ready = 1'b0;
        in_valid  = 1'b1;
        rand_word();
        for (int i = 0; i < 3; i++) begin
            tick(acc);
            if (acc) rand_word();
        end
        check("full_out_valid", 32'(out_valid), 32'd1);
        check("full_in_ready", 32'(in_ready), 32'd0);
        rst = 1'b1;
        #1;
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        check("midrst_out_sat", 32'(out_sat), 32'd0);
        check("midrst_in_ready", 32'(in_ready), 32'd0);
        sb.delete();
        stall_prev = 1'b0;
        in_valid   = 1'b0;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        chk_lat   = 1'b1;
        single("t6", 1'b0, 4'd5, 8'h33, 12'h026, 1'b0);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
